// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round-constant parameters, key-schedule
// state encoding and the GF(2^8) doubling helper.
package aes_pkg;

  localparam int         AES_NR        = 10;
  localparam int         AES_KEY_W     = 128;
  localparam int         AES_WORD_W    = 32;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    if (b[7]) begin
      r = {b[6:0], 1'b0} ^ AES_RCON_POLY;
    end else begin
      r = {b[6:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational lookup. Shared by the key schedule
// and the encryptor datapath.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  localparam logic [7:0] LUT [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = LUT[data];

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: latches the cipher key on Start and derives one round
// key per clock into a register file read back by the decryptor via SelKey.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [KEY_W-1:0] Key,
  input  logic             Start,
  input  logic [3:0]       SelKey,
  output logic [KEY_W-1:0] RoundKey,
  output logic             Busy,
  output logic             Ry
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_e             state_r;
  ks_state_e             state_nxt_s;
  logic                  load_s;
  logic                  step_s;
  logic                  last_s;
  logic [3:0]            counter_r;
  logic [7:0]            rcon_r;
  logic                  busy_r;
  logic                  ry_r;
  logic [KEY_W-1:0]      rk_r [0:NR];
  logic [KEY_W-1:0]      prev_rk_s;
  logic [KEY_W-1:0]      next_rk_s;
  logic [AES_WORD_W-1:0] w0_s, w1_s, w2_s, w3_s;
  logic [AES_WORD_W-1:0] rot_s, sub_s, t_s;
  logic [AES_WORD_W-1:0] n0_s, n1_s, n2_s, n3_s;

  // Source round key for the current step; guarded so the index never leaves the file.
  always_comb begin
    prev_rk_s = '0;
    if ((counter_r != 4'd0) && (counter_r <= (LAST_IDX + 4'd1))) begin
      prev_rk_s = rk_r[counter_r - 4'd1];
    end else begin
      prev_rk_s = '0;
    end
  end

  assign {w0_s, w1_s, w2_s, w3_s} = prev_rk_s;
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .data (rot_s[8*g +: 8]),
      .sub  (sub_s[8*g +: 8])
    );
  end

  assign t_s       = sub_s ^ {rcon_r, 24'h000000};
  assign n0_s      = w0_s ^ t_s;
  assign n1_s      = w1_s ^ n0_s;
  assign n2_s      = w2_s ^ n1_s;
  assign n3_s      = w3_s ^ n2_s;
  assign next_rk_s = {n0_s, n1_s, n2_s, n3_s};

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; Start is only honoured outside EXPAND.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          load_s      = 1'b1;
          state_nxt_s = ST_EXPAND;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_EXPAND: begin
        step_s = 1'b1;
        if (counter_r == LAST_IDX) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXPAND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign last_s = step_s && (counter_r == LAST_IDX);

  // Round-key file, counter, round constant and status flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      counter_r <= 4'd0;
      rcon_r    <= AES_RCON_INIT;
      busy_r    <= 1'b0;
      ry_r      <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        rk_r[i] <= '0;
      end
    end else if (load_s) begin
      rk_r[0]   <= Key;
      rcon_r    <= AES_RCON_INIT;
      counter_r <= 4'd1;
      busy_r    <= 1'b1;
      ry_r      <= 1'b0;
    end else if (step_s) begin
      rk_r[counter_r] <= next_rk_s;
      rcon_r          <= xtime(rcon_r);
      counter_r       <= counter_r + 4'd1;
      if (last_s) begin
        busy_r <= 1'b0;
        ry_r   <= 1'b1;
      end else begin
        busy_r <= busy_r;
        ry_r   <= ry_r;
      end
    end else begin
      counter_r <= counter_r;
      rcon_r    <= rcon_r;
      busy_r    <= busy_r;
      ry_r      <= ry_r;
    end
  end

  // Combinational read port; indices past the last round read as zero.
  always_comb begin
    RoundKey = '0;
    if (SelKey <= LAST_IDX) begin
      RoundKey = rk_r[SelKey];
    end else begin
      RoundKey = '0;
    end
  end

  assign Busy = busy_r;
  assign Ry   = ry_r;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion using the FIPS-197 A.1 and C.1 key
// schedules, restart, ignored-Start and mid-expansion reset scenarios.
module tb_aes_key_expansion;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [127:0] Key;
  logic         Start;
  logic [3:0]   SelKey;
  logic [127:0] RoundKey;
  logic         Busy;
  logic         Ry;

  int n_checks = 0;
  int n_errors = 0;

  aes_key_expansion dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Key      (Key),
    .Start    (Start),
    .SelKey   (SelKey),
    .RoundKey (RoundKey),
    .Busy     (Busy),
    .Ry       (Ry)
  );

  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_key(input string tag, input logic [3:0] sel, input logic [127:0] exp);
    @(negedge Clk);
    SelKey = sel;
    #1;
    check_value(tag, RoundKey, exp);
  endtask

  // Pulses Start with key, optionally re-pulses Start with alt_key while expanding,
  // and measures edges until Ry (E0 counts as the first) and the Busy span.
  task automatic run_schedule(input string tag, input logic [127:0] key,
                              input int pulse_at, input logic [127:0] alt_key);
    int   edges;
    int   busy_span;
    logic busy_prev;
    @(negedge Clk);
    Key   = key;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Key   = ~key;
    check_value({tag, "_busy_e0"}, 128'(Busy), 128'd1);
    check_value({tag, "_ry_e0"}, 128'(Ry), 128'd0);
    edges     = 1;
    busy_span = 1;
    while (!Ry && edges < 40) begin
      if (edges == pulse_at) begin
        Start = 1'b1;
        Key   = alt_key;
      end
      busy_prev = Busy;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      Key   = ~key;
      edges++;
      if (busy_prev) busy_span++;
    end
    check_value({tag, "_ry_edges"}, 128'(edges), 128'd11);
    check_value({tag, "_busy_span"}, 128'(busy_span), 128'd11);
    check_value({tag, "_busy_done"}, 128'(Busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Rst    = 1'b1;
    Start  = 1'b0;
    Key    = '0;
    SelKey = 4'd0;
    repeat (2) @(posedge Clk);
    #1;
    check_value("rst_busy", 128'(Busy), 128'd0);
    check_value("rst_ry", 128'(Ry), 128'd0);
    Rst = 1'b0;
    read_key("rst_rk0", 4'd0, '0);
    read_key("rst_rk10", 4'd10, '0);

    // FIPS-197 A.1
    run_schedule("a1", KEY_A1, 0, '0);
    read_key("a1_rk0", 4'd0, KEY_A1);
    read_key("a1_rk1", 4'd1, A1_RK1);
    read_key("a1_rk2", 4'd2, A1_RK2);
    read_key("a1_rk10", 4'd10, A1_RK10);

    // FIPS-197 C.1, restarting from DONE
    run_schedule("c1", KEY_C1, 0, '0);
    read_key("c1_rk0", 4'd0, KEY_C1);
    read_key("c1_rk1", 4'd1, C1_RK1);
    read_key("c1_rk10", 4'd10, C1_RK10);

    // Start re-pulsed mid-expansion with another key must be ignored
    run_schedule("ign", KEY_A1, 4, KEY_C1);
    read_key("ign_rk0", 4'd0, KEY_A1);
    read_key("ign_rk1", 4'd1, A1_RK1);
    read_key("ign_rk10", 4'd10, A1_RK10);

    // Reset in the middle of an expansion clears everything
    @(negedge Clk);
    Key   = KEY_C1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    check_value("mid_rst_busy", 128'(Busy), 128'd0);
    check_value("mid_rst_ry", 128'(Ry), 128'd0);
    for (int i = 0; i <= 10; i++) begin
      read_key($sformatf("mid_rst_rk%0d", i), 4'(i), '0);
    end

    run_schedule("c1b", KEY_C1, 0, '0);
    read_key("c1b_rk0", 4'd0, KEY_C1);
    read_key("c1b_rk1", 4'd1, C1_RK1);
    read_key("c1b_rk10", 4'd10, C1_RK10);

    // Restart from DONE with the A.1 key after C.1
    run_schedule("a1b", KEY_A1, 0, '0);
    read_key("a1b_rk1", 4'd1, A1_RK1);
    read_key("a1b_rk10", 4'd10, A1_RK10);

    // Out-of-range selects read as zero; Ry holds in DONE
    for (int s = 11; s <= 15; s++) begin
      read_key($sformatf("sel%0d_zero", s), 4'(s), '0);
    end
    check_value("ry_hold", 128'(Ry), 128'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
